// File: rtl/pipe_bus_ctrl_if.sv
// rtl/pipe_bus_ctrl_if.sv - pipeline-control and shared memory bus signal bundle for pipe_bus_ctrl
interface pipe_bus_ctrl_if;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        if_req;
    logic        mem_req;
    logic        mem_we;
    logic        bus_ack;
    logic        excp_req;
    logic [31:0] excp_pc;
    logic        bus_req;
    logic        bus_sel;
    logic        bus_we;
    logic        if_done;
    logic        mem_done;
    logic        bus_err;
    logic        flush;
    logic [31:0] new_pc;
    logic [5:0]  stall;

    // Controller side
    modport master (
        input  stallreq_from_id, stallreq_from_ex, if_req, mem_req, mem_we,
        input  bus_ack, excp_req, excp_pc,
        output bus_req, bus_sel, bus_we, if_done, mem_done, bus_err,
        output flush, new_pc, stall
    );

    // Pipeline and memory side
    modport slave (
        output stallreq_from_id, stallreq_from_ex, if_req, mem_req, mem_we,
        output bus_ack, excp_req, excp_pc,
        input  bus_req, bus_sel, bus_we, if_done, mem_done, bus_err,
        input  flush, new_pc, stall
    );
endinterface

// File: rtl/pipe_bus_ctrl.sv
// rtl/pipe_bus_ctrl.sv - IF/MEM bus arbiter, stall merger and exception flush sequencer
module pipe_bus_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    pipe_bus_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, IF_DROP} state_t;

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

    state_t          state, state_nxt, grant_state;
    logic [TO_W-1:0] wd, wd_nxt;
    logic            we_q, we_nxt;
    logic            pending, pending_nxt;
    logic            release_q, release_nxt;
    logic [31:0]     pc_q, pc_nxt;
    logic            pend_set;
    logic            timeout_hit;
    logic            flush_c, if_done_c, mem_done_c, bus_err_c;
    logic [5:0]      stall_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wd        <= '0;
            we_q      <= 1'b0;
            pending   <= 1'b0;
            release_q <= 1'b0;
            pc_q      <= '0;
        end else begin
            state     <= state_nxt;
            wd        <= wd_nxt;
            we_q      <= we_nxt;
            pending   <= pending_nxt;
            release_q <= release_nxt;
            pc_q      <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        we_nxt      = we_q;
        if_done_c   = 1'b0;
        mem_done_c  = 1'b0;
        bus_err_c   = 1'b0;
        // A deferred exception fires the cycle after the MEM transfer ends;
        // fresh exceptions flush immediately unless MEM owns the bus.
        flush_c     = release_q || (bus.excp_req && (state != MEM_BUSY) && !pending);
        timeout_hit = (state != IDLE) && !bus.bus_ack && (wd == WD_LAST);

        if (bus.mem_req)
            grant_state = MEM_BUSY;
        else if (bus.if_req && !flush_c)
            grant_state = IF_BUSY;
        else
            grant_state = IDLE;

        case (state)
            IDLE: begin
                state_nxt = grant_state;
            end
            IF_BUSY: begin
                if (bus.bus_ack) begin
                    if (flush_c) begin
                        state_nxt = IDLE;
                    end else begin
                        if_done_c = 1'b1;
                        state_nxt = grant_state;
                    end
                end else if (timeout_hit) begin
                    bus_err_c = 1'b1;
                    state_nxt = IDLE;
                end else if (flush_c) begin
                    state_nxt = IF_DROP;
                end
            end
            MEM_BUSY: begin
                if (bus.bus_ack) begin
                    mem_done_c = 1'b1;
                    state_nxt  = grant_state;
                end else if (timeout_hit) begin
                    bus_err_c = 1'b1;
                    state_nxt = IDLE;
                end
            end
            IF_DROP: begin
                if (bus.bus_ack) begin
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    bus_err_c = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if ((state_nxt == MEM_BUSY) && (state == IDLE || bus.bus_ack))
            we_nxt = bus.mem_we;

        // Restart the watchdog on every new grant or state change.
        if ((state != IDLE) && !bus.bus_ack && (state_nxt == state))
            wd_nxt = wd + TO_W'(1);
        else
            wd_nxt = '0;

        pend_set    = bus.excp_req && (state == MEM_BUSY) && !pending;
        pending_nxt = release_q ? 1'b0 : (pending || pend_set);
        pc_nxt      = pend_set ? bus.excp_pc : pc_q;
        release_nxt = (pending || pend_set) && (mem_done_c || bus_err_c) && !release_q;

        if (flush_c)
            stall_c = 6'b000000;
        else if (((state == MEM_BUSY) && !bus.bus_ack) || pending)
            stall_c = 6'b011111;
        else if (bus.stallreq_from_ex)
            stall_c = 6'b001111;
        else if (bus.stallreq_from_id)
            stall_c = 6'b000111;
        else if ((bus.if_req && !if_done_c) || (state == IF_DROP))
            stall_c = 6'b000011;
        else
            stall_c = 6'b000000;
    end

    assign bus.bus_req  = (state != IDLE);
    assign bus.bus_sel  = (state == MEM_BUSY);
    assign bus.bus_we   = (state == MEM_BUSY) && we_q;
    assign bus.if_done  = if_done_c && !rst;
    assign bus.mem_done = mem_done_c && !rst;
    assign bus.bus_err  = bus_err_c && !rst;
    assign bus.flush    = flush_c && !rst;
    assign bus.new_pc   = (flush_c && !rst) ? (release_q ? pc_q : bus.excp_pc) : 32'h0;
    assign bus.stall    = rst ? 6'b000000 : stall_c;
endmodule

// File: tb/tb_pipe_bus_ctrl.sv
// tb/tb_pipe_bus_ctrl.sv - scoreboard bench for pipe_bus_ctrl arbitration, stalls, flushes and watchdog
module tb_pipe_bus_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_bus_ctrl_if bif();

    pipe_bus_ctrl #(.TIMEOUT(4), .TO_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic is_mem;
        logic we;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic [12:0] exp;

    // {bus_req, bus_sel, bus_we, if_done, mem_done, bus_err, flush, stall[5:0]}
    function automatic logic [12:0] snap();
        return {bif.bus_req, bif.bus_sel, bif.bus_we, bif.if_done, bif.mem_done,
                bif.bus_err, bif.flush, bif.stall};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        #1;
        exp = 13'b0; checks++; if (snap() !== exp) begin errors++; $display("FAIL reset_hold got %b exp %b", snap(), exp); end
        rst = 1'b0;
        #1;
        exp = 13'b0; checks++; if (snap() !== exp) begin errors++; $display("FAIL reset_release got %b exp %b", snap(), exp); end
        checks++; if (bif.new_pc !== 32'h0) begin errors++; $display("FAIL reset_new_pc got %h exp 0", bif.new_pc); end
        tick();
    endtask

    task automatic test_if_fetch();
        bif.if_req = 1'b1; sb.push_back('{is_mem: 1'b0, we: 1'b0}); #1;
        exp = {3'b000, 4'b0000, 6'b000011}; checks++; if (snap() !== exp) begin errors++; $display("FAIL if_idle got %b exp %b", snap(), exp); end
        tick(); #1;
        exp = {3'b100, 4'b0000, 6'b000011}; checks++; if (snap() !== exp) begin errors++; $display("FAIL if_wait1 got %b exp %b", snap(), exp); end
        tick(); #1;
        checks++; if (snap() !== exp) begin errors++; $display("FAIL if_wait2 got %b exp %b", snap(), exp); end
        tick();
        bif.bus_ack = 1'b1; sb.push_back('{is_mem: 1'b0, we: 1'b0}); #1;
        exp = {3'b100, 4'b1000, 6'b000000}; checks++; if (snap() !== exp) begin errors++; $display("FAIL if_ack got %b exp %b", snap(), exp); end
        checks++; if (sb.size() == 0) begin errors++; $display("FAIL sb_if_ack got done exp none"); end
        else begin e = sb.pop_front(); if ({bif.mem_done, bif.if_done, bif.bus_we} !== {e.is_mem, ~e.is_mem, e.we}) begin errors++; $display("FAIL sb_if_ack got %b exp %b", {bif.mem_done, bif.if_done, bif.bus_we}, {e.is_mem, ~e.is_mem, e.we}); end end
        tick();
        bif.if_req = 1'b0; #1;
        exp = {3'b100, 4'b1000, 6'b000000}; checks++; if (snap() !== exp) begin errors++; $display("FAIL if_regrant got %b exp %b", snap(), exp); end
        checks++; if (sb.size() == 0) begin errors++; $display("FAIL sb_if_regrant got done exp none"); end
        else begin e = sb.pop_front(); if ({bif.mem_done, bif.if_done, bif.bus_we} !== {e.is_mem, ~e.is_mem, e.we}) begin errors++; $display("FAIL sb_if_regrant got %b exp %b", {bif.mem_done, bif.if_done, bif.bus_we}, {e.is_mem, ~e.is_mem, e.we}); end end
        tick();
        bif.bus_ack = 1'b0; #1;
        exp = 13'b0; checks++; if (snap() !== exp) begin errors++; $display("FAIL if_end got %b exp %b", snap(), exp); end
        tick();
    endtask

    task automatic test_mem_priority();
        bif.if_req = 1'b1; bif.mem_req = 1'b1; bif.mem_we = 1'b1;
        sb.push_back('{is_mem: 1'b1, we: 1'b1}); sb.push_back('{is_mem: 1'b0, we: 1'b0}); #1;
        exp = {3'b000, 4'b0000, 6'b000011}; checks++; if (snap() !== exp) begin errors++; $display("FAIL prio_idle got %b exp %b", snap(), exp); end
        tick();
        bif.mem_req = 1'b0; bif.mem_we = 1'b0; #1;
        exp = {3'b111, 4'b0000, 6'b011111}; checks++; if (snap() !== exp) begin errors++; $display("FAIL prio_mem_busy got %b exp %b", snap(), exp); end
        tick();
        bif.bus_ack = 1'b1; #1;
        exp = {3'b111, 4'b0100, 6'b000011}; checks++; if (snap() !== exp) begin errors++; $display("FAIL prio_mem_ack got %b exp %b", snap(), exp); end
        checks++; if (sb.size() == 0) begin errors++; $display("FAIL sb_prio_mem got done exp none"); end
        else begin e = sb.pop_front(); if ({bif.mem_done, bif.if_done, bif.bus_we} !== {e.is_mem, ~e.is_mem, e.we}) begin errors++; $display("FAIL sb_prio_mem got %b exp %b", {bif.mem_done, bif.if_done, bif.bus_we}, {e.is_mem, ~e.is_mem, e.we}); end end
        tick();
        bif.bus_ack = 1'b0; #1;
        exp = {3'b100, 4'b0000, 6'b000011}; checks++; if (snap() !== exp) begin errors++; $display("FAIL prio_if_busy got %b exp %b", snap(), exp); end
        tick();
        bif.bus_ack = 1'b1; bif.if_req = 1'b0; #1;
        exp = {3'b100, 4'b1000, 6'b000000}; checks++; if (snap() !== exp) begin errors++; $display("FAIL prio_if_ack got %b exp %b", snap(), exp); end
        checks++; if (sb.size() == 0) begin errors++; $display("FAIL sb_prio_if got done exp none"); end
        else begin e = sb.pop_front(); if ({bif.mem_done, bif.if_done, bif.bus_we} !== {e.is_mem, ~e.is_mem, e.we}) begin errors++; $display("FAIL sb_prio_if got %b exp %b", {bif.mem_done, bif.if_done, bif.bus_we}, {e.is_mem, ~e.is_mem, e.we}); end end
        tick();
        bif.bus_ack = 1'b0; #1;
        exp = 13'b0; checks++; if (snap() !== exp) begin errors++; $display("FAIL prio_end got %b exp %b", snap(), exp); end
        tick();
    endtask

    task automatic test_if_flush();
        bif.if_req = 1'b1; #1;
        tick();
        bif.if_req = 1'b0; bif.excp_req = 1'b1; bif.excp_pc = 32'h0000_0020; #1;
        exp = {3'b100, 4'b0001, 6'b000000}; checks++; if (snap() !== exp) begin errors++; $display("FAIL ifx_flush got %b exp %b", snap(), exp); end
        checks++; if (bif.new_pc !== 32'h20) begin errors++; $display("FAIL ifx_new_pc got %h exp 00000020", bif.new_pc); end
        tick();
        bif.excp_req = 1'b0; bif.excp_pc = 32'h0; #1;
        exp = {3'b100, 4'b0000, 6'b000011}; checks++; if (snap() !== exp) begin errors++; $display("FAIL ifx_drop1 got %b exp %b", snap(), exp); end
        checks++; if (bif.new_pc !== 32'h0) begin errors++; $display("FAIL ifx_new_pc_idle got %h exp 0", bif.new_pc); end
        tick(); #1;
        checks++; if (snap() !== exp) begin errors++; $display("FAIL ifx_drop2 got %b exp %b", snap(), exp); end
        tick();
        bif.bus_ack = 1'b1; #1;
        exp = {3'b100, 4'b0000, 6'b000011}; checks++; if (snap() !== exp) begin errors++; $display("FAIL ifx_drop_ack got %b exp %b", snap(), exp); end
        tick();
        bif.bus_ack = 1'b0; #1;
        exp = 13'b0; checks++; if (snap() !== exp) begin errors++; $display("FAIL ifx_end got %b exp %b", snap(), exp); end
        tick();
    endtask

    task automatic test_mem_excp();
        bif.mem_req = 1'b1; bif.mem_we = 1'b0; sb.push_back('{is_mem: 1'b1, we: 1'b0}); #1;
        tick();
        bif.mem_req = 1'b0; bif.excp_req = 1'b1; bif.excp_pc = 32'h0000_0040; #1;
        exp = {3'b110, 4'b0000, 6'b011111}; checks++; if (snap() !== exp) begin errors++; $display("FAIL mx_hold got %b exp %b", snap(), exp); end
        checks++; if (bif.new_pc !== 32'h0) begin errors++; $display("FAIL mx_new_pc_hold got %h exp 0", bif.new_pc); end
        tick();
        bif.excp_pc = 32'h0000_0099; #1;
        checks++; if (snap() !== exp) begin errors++; $display("FAIL mx_second_excp got %b exp %b", snap(), exp); end
        tick();
        bif.excp_req = 1'b0; bif.excp_pc = 32'h0; bif.bus_ack = 1'b1; #1;
        exp = {3'b110, 4'b0100, 6'b011111}; checks++; if (snap() !== exp) begin errors++; $display("FAIL mx_ack got %b exp %b", snap(), exp); end
        checks++; if (sb.size() == 0) begin errors++; $display("FAIL sb_mx got done exp none"); end
        else begin e = sb.pop_front(); if ({bif.mem_done, bif.if_done, bif.bus_we} !== {e.is_mem, ~e.is_mem, e.we}) begin errors++; $display("FAIL sb_mx got %b exp %b", {bif.mem_done, bif.if_done, bif.bus_we}, {e.is_mem, ~e.is_mem, e.we}); end end
        tick();
        bif.bus_ack = 1'b0; #1;
        exp = {3'b000, 4'b0001, 6'b000000}; checks++; if (snap() !== exp) begin errors++; $display("FAIL mx_release got %b exp %b", snap(), exp); end
        checks++; if (bif.new_pc !== 32'h40) begin errors++; $display("FAIL mx_new_pc got %h exp 00000040", bif.new_pc); end
        tick(); #1;
        exp = 13'b0; checks++; if (snap() !== exp) begin errors++; $display("FAIL mx_end got %b exp %b", snap(), exp); end
        tick();
    endtask

    task automatic test_timeout();
        bif.mem_req = 1'b1; bif.mem_we = 1'b1; #1;
        tick();
        bif.mem_req = 1'b0; bif.excp_req = 1'b1; bif.excp_pc = 32'h0000_0080; #1;
        exp = {3'b111, 4'b0000, 6'b011111};
        for (int i = 1; i <= 3; i++) begin
            checks++; if (snap() !== exp) begin errors++; $display("FAIL to_wait%0d got %b exp %b", i, snap(), exp); end
            tick();
            bif.excp_req = 1'b0; bif.excp_pc = 32'h0; #1;
        end
        exp = {3'b111, 4'b0010, 6'b011111}; checks++; if (snap() !== exp) begin errors++; $display("FAIL to_err got %b exp %b", snap(), exp); end
        tick(); #1;
        exp = {3'b000, 4'b0001, 6'b000000}; checks++; if (snap() !== exp) begin errors++; $display("FAIL to_release got %b exp %b", snap(), exp); end
        checks++; if (bif.new_pc !== 32'h80) begin errors++; $display("FAIL to_new_pc got %h exp 00000080", bif.new_pc); end
        tick(); #1;
        exp = 13'b0; checks++; if (snap() !== exp) begin errors++; $display("FAIL to_end got %b exp %b", snap(), exp); end
        tick();
    endtask

    task automatic test_back_to_back();
        bif.mem_req = 1'b1; bif.mem_we = 1'b1; sb.push_back('{is_mem: 1'b1, we: 1'b1}); #1;
        tick();
        bif.bus_ack = 1'b1; bif.mem_we = 1'b0; sb.push_back('{is_mem: 1'b1, we: 1'b0}); #1;
        exp = {3'b111, 4'b0100, 6'b000000}; checks++; if (snap() !== exp) begin errors++; $display("FAIL b2b_first got %b exp %b", snap(), exp); end
        checks++; if (sb.size() == 0) begin errors++; $display("FAIL sb_b2b_first got done exp none"); end
        else begin e = sb.pop_front(); if ({bif.mem_done, bif.if_done, bif.bus_we} !== {e.is_mem, ~e.is_mem, e.we}) begin errors++; $display("FAIL sb_b2b_first got %b exp %b", {bif.mem_done, bif.if_done, bif.bus_we}, {e.is_mem, ~e.is_mem, e.we}); end end
        tick();
        bif.mem_req = 1'b0; #1;
        exp = {3'b110, 4'b0100, 6'b000000}; checks++; if (snap() !== exp) begin errors++; $display("FAIL b2b_second got %b exp %b", snap(), exp); end
        checks++; if (sb.size() == 0) begin errors++; $display("FAIL sb_b2b_second got done exp none"); end
        else begin e = sb.pop_front(); if ({bif.mem_done, bif.if_done, bif.bus_we} !== {e.is_mem, ~e.is_mem, e.we}) begin errors++; $display("FAIL sb_b2b_second got %b exp %b", {bif.mem_done, bif.if_done, bif.bus_we}, {e.is_mem, ~e.is_mem, e.we}); end end
        tick();
        bif.bus_ack = 1'b0; #1;
        exp = 13'b0; checks++; if (snap() !== exp) begin errors++; $display("FAIL b2b_end got %b exp %b", snap(), exp); end
        tick();
    endtask

    task automatic test_stall_merge();
        bif.stallreq_from_id = 1'b1; bif.stallreq_from_ex = 1'b1; #1;
        exp = {3'b000, 4'b0000, 6'b001111}; checks++; if (snap() !== exp) begin errors++; $display("FAIL stall_ex_id got %b exp %b", snap(), exp); end
        bif.stallreq_from_ex = 1'b0; #1;
        exp = {3'b000, 4'b0000, 6'b000111}; checks++; if (snap() !== exp) begin errors++; $display("FAIL stall_id got %b exp %b", snap(), exp); end
        bif.stallreq_from_id = 1'b0; #1;
        exp = 13'b0; checks++; if (snap() !== exp) begin errors++; $display("FAIL stall_none got %b exp %b", snap(), exp); end
        tick();
    endtask

    task automatic test_reset_mid();
        bif.if_req = 1'b1; #1;
        tick(); #1;
        exp = {3'b100, 4'b0000, 6'b000011}; checks++; if (snap() !== exp) begin errors++; $display("FAIL rstmid_busy got %b exp %b", snap(), exp); end
        rst = 1'b1;
        tick(); #1;
        exp = 13'b0; checks++; if (snap() !== exp) begin errors++; $display("FAIL rstmid_after got %b exp %b", snap(), exp); end
        checks++; if (bif.new_pc !== 32'h0) begin errors++; $display("FAIL rstmid_new_pc got %h exp 0", bif.new_pc); end
        rst = 1'b0; bif.if_req = 1'b0;
        tick(); #1;
        exp = 13'b0; checks++; if (snap() !== exp) begin errors++; $display("FAIL rstmid_idle got %b exp %b", snap(), exp); end
        tick();
    endtask

    initial begin
        bif.stallreq_from_id = 1'b0;
        bif.stallreq_from_ex = 1'b0;
        bif.if_req           = 1'b0;
        bif.mem_req          = 1'b0;
        bif.mem_we           = 1'b0;
        bif.bus_ack          = 1'b0;
        bif.excp_req         = 1'b0;
        bif.excp_pc          = 32'h0;
        test_reset();
        test_if_fetch();
        test_mem_priority();
        test_if_flush();
        test_mem_excp();
        test_timeout();
        test_back_to_back();
        test_stall_merge();
        test_reset_mid();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout got running exp finished");
        $fatal(1, "simulation time limit");
    end
endmodule
